// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for IF and MEM pipeline requesters
//
// Purpose: serialises instruction fetches and data accesses onto one memory
// port with a request/grant/response handshake. Data has fixed priority; with
// MEM_ARB_STARVE_GUARD_EN defined, fetch is forced through after MAX_DSTREAK
// consecutive data grants made while a fetch was waiting.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request level and address
//   if_rdata/if_valid        fetched word and one-cycle completion pulse
//   if_stall                 fetch pending and not completing this cycle
//   d_req/d_we/d_addr        data request level, direction, address
//   d_wdata/d_be             store data and byte enables
//   d_rdata/d_valid          load data and one-cycle completion pulse
//   d_stall                  data pending and not completing this cycle
//   m_req/m_we/m_addr        memory request, direction, address
//   m_wdata/m_be             memory write data and byte enables
//   m_gnt                    memory accepted the request this cycle
//   m_rvalid/m_rdata         memory response (read data or write ack)
//   err                      one-cycle pulse when a response timed out
//   owner                    requester of current/last grant (0 fetch, 1 data)

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_DSTREAK    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err,
  output logic              owner
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] FETCH_NOP = DATA_W'(32'h0000_0013);

  // The streak counter is 3 bits wide, so the threshold must fit in it.
  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 7) begin : g_bad_streak
    $error("MAX_DSTREAK must be in 1..7");
  end

  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RESP_I, RESP_D} state_t;

  state_t            state, state_nx;
  logic [TCNT_W-1:0] tcnt;
  logic              accept, pick_d, pick_i, starve;
  logic              resp, timeout, finish;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] streak;
  assign starve = (streak >= 3'(MAX_DSTREAK));
`else
  assign starve = 1'b0;
`endif

  // During a completion pulse the finishing requester still holds its
  // request; sampling then would reissue the same access, so IDLE skips it.
  assign accept  = (state == IDLE) && !(if_valid || d_valid);
  assign pick_d  = accept && d_req && !(starve && if_req);
  assign pick_i  = accept && if_req && !pick_d;
  assign resp    = (state == RESP_I) || (state == RESP_D);
  assign timeout = resp && !m_rvalid && (tcnt == TCNT_LAST);
  assign finish  = resp && (m_rvalid || timeout);

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m_req    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d)      state_nx = REQ_D;
        else if (pick_i) state_nx = REQ_I;
      end
      REQ_I: begin
        m_req = 1'b1;
        if (m_gnt) state_nx = RESP_I;
      end
      REQ_D: begin
        m_req = 1'b1;
        if (m_gnt) state_nx = RESP_D;
      end
      RESP_I, RESP_D: begin
        if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= 4'h0;
      owner    <= 1'b0;
      tcnt     <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;

      // Memory-side fields are loaded only on a grant decision, which keeps
      // them stable for the whole request phase.
      if (pick_d) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        owner   <= 1'b1;
      end else if (pick_i) begin
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_be    <= 4'hF;
        owner   <= 1'b0;
      end

      if (m_req && m_gnt)                 tcnt <= '0;
      else if (resp && !m_rvalid && !timeout) tcnt <= tcnt + 1'b1;

      if (finish) begin
        err <= timeout;
        if (state == RESP_I) begin
          if_valid <= 1'b1;
          if_rdata <= m_rvalid ? m_rdata : FETCH_NOP;
        end else begin
          d_valid <= 1'b1;
          // A store ack carries no data; the last load result is kept.
          if (!m_we) d_rdata <= m_rvalid ? m_rdata : '0;
        end
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             streak <= 3'd0;
    else if (!if_req || pick_i)           streak <= 3'd0;
    else if (pick_d && streak != 3'd7)    streak <= streak + 3'd1;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 64;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, m_req, m_we, err, owner;
  logic [3:0]  m_be;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: grants after gnt_delay request cycles, answers in the
  // rv_delay-th response cycle (0 = never), data derived from the address.
  int          gnt_delay = 0, rv_delay = 1;
  logic        use_fixed = 1'b0, stray = 1'b0;
  logic [31:0] fixed_data = '0;
  int          hold_cnt = 0, resp_cnt = 0;
  logic        resp_active = 1'b0;
  logic [31:0] gaddr = '0;

  always @(negedge clk) begin
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'hDEADBEEF;
    if (!rst) begin
      hold_cnt    = 0;
      resp_active = 1'b0;
    end else begin
      if (resp_active) begin
        resp_cnt++;
        if (rv_delay != 0 && resp_cnt == rv_delay) begin
          m_rvalid    = 1'b1;
          m_rdata     = use_fixed ? fixed_data : (gaddr ^ 32'h5A5A1234);
          resp_active = 1'b0;
        end
      end
      if (stray) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'h0BAD0BAD;
      end
      if (m_req) begin
        if (hold_cnt == gnt_delay) begin
          m_gnt       = 1'b1;
          hold_cnt    = 0;
          resp_active = 1'b1;
          resp_cnt    = 0;
          gaddr       = m_addr;
        end else begin
          hold_cnt++;
        end
      end
      if (if_valid || d_valid) resp_active = 1'b0;
    end
  end

  // Transaction-level reference: which requester should own the port, what
  // the memory side must show, and when/what each completion must deliver.
  typedef enum int {P_IDLE, P_REQ, P_RESP} phase_t;
  phase_t      ph = P_IDLE;
  logic        fire = 1'b0, fire_fetch = 1'b0, fire_err = 1'b0, done_now, take_d;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, t_addr = '0, t_wdata = '0;
  logic        e_owner = 1'b0, t_we = 1'b0, t_fetch = 1'b0;
  logic [3:0]  t_be = '0;
  int          wait_cnt = 0, streak = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("rst_m_req", m_req, 0);     chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_be", m_be, 0);       chk("rst_owner", owner, 0);
      chk("rst_if_valid", if_valid, 0); chk("rst_d_valid", d_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
      chk("rst_if_stall", if_stall, if_req); chk("rst_d_stall", d_stall, d_req);
      ph = P_IDLE; fire = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
      e_owner = 1'b0; streak = 0;
    end else begin
      chk("m_req", m_req, ph == P_REQ);
      if (ph == P_REQ) begin
        chk("m_addr", m_addr, t_addr);
        chk("m_we", m_we, t_we);
        chk("m_be", m_be, t_be);
        if (t_we) chk("m_wdata", m_wdata, t_wdata);
      end
      chk("owner", owner, e_owner);
      chk("if_valid", if_valid, fire && fire_fetch);
      chk("d_valid", d_valid, fire && !fire_fetch);
      chk("err", err, fire && fire_err);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("if_stall", if_stall, if_req && !(fire && fire_fetch));
      chk("d_stall", d_stall, d_req && !(fire && !fire_fetch));

      done_now = fire;
      fire = 1'b0;
      if (!if_req) streak = 0;
      case (ph)
        P_IDLE: if (!done_now && (d_req || if_req)) begin
          take_d = d_req && !(GUARD && if_req && streak >= 4);
          if (take_d) begin
            t_addr = d_addr; t_we = d_we; t_wdata = d_wdata; t_be = d_be;
            t_fetch = 1'b0; e_owner = 1'b1;
            if (if_req && streak < 7) streak++;
          end else begin
            t_addr = if_addr; t_we = 1'b0; t_wdata = '0; t_be = 4'hF;
            t_fetch = 1'b1; e_owner = 1'b0; streak = 0;
          end
          ph = P_REQ;
        end
        P_REQ: if (m_gnt) begin
          ph = P_RESP;
          wait_cnt = 0;
        end
        P_RESP: begin
          if (m_rvalid) begin
            fire = 1'b1; fire_fetch = t_fetch; fire_err = 1'b0;
            if (t_fetch) e_if_rdata = m_rdata;
            else if (!t_we) e_d_rdata = m_rdata;
            ph = P_IDLE;
          end else begin
            wait_cnt++;
            if (wait_cnt == TO) begin
              fire = 1'b1; fire_fetch = t_fetch; fire_err = 1'b1;
              if (t_fetch) e_if_rdata = 32'h0000_0013;
              else if (!t_we) e_d_rdata = 32'h0;
              ph = P_IDLE;
            end
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #7;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   found, n, dcount, gcount, fetch_pos;
  logic prev_mreq, ifdone, drop_d, drop_i;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick(); look();

    // Single fetch, minimum latency.
    use_fixed = 1'b1; fixed_data = 32'h00500093; gnt_delay = 0; rv_delay = 1;
    tick(); if_req = 1'b1; if_addr = 32'h100; look();
    chk("t1_c0_if_stall", if_stall, 1);
    tick(); look();
    chk("t1_c1_m_req", m_req, 1); chk("t1_c1_m_addr", m_addr, 32'h100);
    chk("t1_c1_m_we", m_we, 0);   chk("t1_c1_if_stall", if_stall, 1);
    tick(); look();
    chk("t1_c2_m_req", m_req, 0); chk("t1_c2_if_stall", if_stall, 1);
    tick(); look();
    chk("t1_c3_if_valid", if_valid, 1); chk("t1_c3_if_rdata", if_rdata, 32'h00500093);
    chk("t1_c3_if_stall", if_stall, 0);
    tick(); if_req = 1'b0; look();
    chk("t1_c4_if_valid", if_valid, 0);
    use_fixed = 1'b0;
    tick(); look();

    // Store with three cycles of grant backpressure.
    gnt_delay = 3; rv_delay = 2;
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_be = 4'b0011; look();
    for (int c = 1; c <= 4; c++) begin
      tick(); look();
      chk("t2_req_m_req", m_req, 1);      chk("t2_req_m_addr", m_addr, 32'h2000);
      chk("t2_req_m_wdata", m_wdata, 32'hCAFEF00D);
      chk("t2_req_m_be", m_be, 4'b0011);  chk("t2_req_m_we", m_we, 1);
      chk("t2_req_owner", owner, 1);      chk("t2_req_d_valid", d_valid, 0);
    end
    tick(); look(); chk("t2_c5_d_valid", d_valid, 0);
    tick(); look(); chk("t2_c6_d_valid", d_valid, 0);
    tick(); look();
    chk("t2_c7_d_valid", d_valid, 1); chk("t2_c7_d_rdata_held", d_rdata, 0);
    tick(); d_req = 1'b0; d_we = 1'b0; look();
    chk("t2_c8_d_valid", d_valid, 0);
    tick(); look();

    // Collision: data first, then fetch.
    gnt_delay = 0; rv_delay = 1;
    tick(); if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_addr = 32'h3000; d_be = 4'hF; look();
    tick(); look();
    chk("t3_c1_owner", owner, 1); chk("t3_c1_m_addr", m_addr, 32'h3000);
    tick(); look();
    tick(); look();
    chk("t3_c3_d_valid", d_valid, 1); chk("t3_c3_d_rdata", d_rdata, 32'h5A5A2234);
    tick(); d_req = 1'b0; look();
    tick(); look();
    chk("t3_c5_m_req", m_req, 1); chk("t3_c5_owner", owner, 0);
    chk("t3_c5_m_addr", m_addr, 32'h104);
    tick(); look();
    tick(); look();
    chk("t3_c7_if_valid", if_valid, 1); chk("t3_c7_if_rdata", if_rdata, 32'h5A5A1330);
    tick(); if_req = 1'b0; look();
    tick(); look();

    // Fetch timeout.
    gnt_delay = 0; rv_delay = 0;
    tick(); if_req = 1'b1; if_addr = 32'h200; look();
    found = 0; n = 0;
    for (int c = 1; c <= 80 && found == 0; c++) begin
      tick(); look();
      if (if_valid) begin found = 1; n = c; end
    end
    chk("t4_completed", found, 1);
    chk("t4_cycle", n, 66);
    chk("t4_err", err, 1);
    chk("t4_if_rdata", if_rdata, 32'h00000013);
    tick(); if_req = 1'b0; look();
    chk("t4_err_after", err, 0);
    tick(); look();

    // Reset during the data response phase.
    gnt_delay = 0; rv_delay = 3;
    tick(); d_req = 1'b1; d_addr = 32'h3100; look();
    tick(); look();
    tick(); look(); chk("t5_resp_m_req", m_req, 0);
    tick(); rst = 1'b0; d_req = 1'b0; #1;
    chk("t5_rst_owner", owner, 0); chk("t5_rst_d_rdata", d_rdata, 0);
    chk("t5_rst_m_addr", m_addr, 0);
    look();
    tick(); rst = 1'b1; stray = 1'b1; look();
    chk("t5_stray_d_valid", d_valid, 0);
    tick(); stray = 1'b0; look();
    chk("t5_late_d_valid", d_valid, 0); chk("t5_late_d_rdata", d_rdata, 0);
    tick(); look();
    chk("t5_late2_d_valid", d_valid, 0);

    // Continuous data traffic with a waiting fetch.
    gnt_delay = 0; rv_delay = 1;
    tick(); if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF; look();
    dcount = 0; gcount = 0; fetch_pos = -1; prev_mreq = 1'b0;
    ifdone = 1'b0; drop_d = 1'b0; drop_i = 1'b0;
    for (int c = 0; c < 400 && !(dcount >= 10 && ifdone); c++) begin
      tick();
      if (drop_d) d_req = 1'b0;
      if (drop_i) if_req = 1'b0;
      look();
      if (m_req && !prev_mreq) begin
        if (owner == 1'b0) fetch_pos = gcount;
        gcount++;
      end
      prev_mreq = m_req;
      if (d_valid) begin
        dcount++;
        if (dcount == 10) drop_d = 1'b1;
      end
      if (if_valid) begin
        ifdone = 1'b1;
        drop_i = 1'b1;
      end
    end
    tick(); if_req = 1'b0; d_req = 1'b0; look();
    chk("t6_fetch_done", ifdone, 1);
    chk("t6_data_count", dcount, 10);
    chk("t6_grant_count", gcount, 11);
    chk("t6_fetch_pos", fetch_pos, GUARD ? 4 : 10);
    repeat (3) begin tick(); look(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
